// File: rtl/lfsr_pkg.sv
// Shared constants and types for the serial PRBS checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    // Feedback taps over the window: bits 0, 2, 3, 4.
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

    // Generator seed; its first eight transmitted bits are 0,0,0,0,0,1,0,0.
    localparam logic [LFSR_W-1:0] SEED = 8'h20;

    typedef enum logic {HUNT, LOCKED} state_e;

    // Next stream bit predicted from the last eight accepted bits (oldest in bit 0).
    function automatic logic predict_bit(input logic [LFSR_W-1:0] win);
        return ^(win & TAP_MASK);
    endfunction

endpackage

// File: rtl/seg.sv
// Hex nibble to seven-segment pattern, active-low, layout {a,b,c,d,e,f,g,dp}.
module seg (
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    logic [7:0] w_seg_on;

    // Active-high segment table; the board drives segments low to light them.
    always_comb begin
        w_seg_on = 8'b0000_0000;
        case (i_hex)
            4'h0: w_seg_on = 8'b1111_1100;
            4'h1: w_seg_on = 8'b0110_0000;
            4'h2: w_seg_on = 8'b1101_1010;
            4'h3: w_seg_on = 8'b1111_0010;
            4'h4: w_seg_on = 8'b0110_0110;
            4'h5: w_seg_on = 8'b1011_0110;
            4'h6: w_seg_on = 8'b1011_1110;
            4'h7: w_seg_on = 8'b1110_0000;
            4'h8: w_seg_on = 8'b1111_1110;
            4'h9: w_seg_on = 8'b1111_0110;
            4'ha: w_seg_on = 8'b1110_1110;
            4'hb: w_seg_on = 8'b0011_1110;
            4'hc: w_seg_on = 8'b1001_1100;
            4'hd: w_seg_on = 8'b0111_1010;
            4'he: w_seg_on = 8'b1001_1110;
            default: w_seg_on = 8'b1000_1110;
        endcase
    end

    assign o_seg = ~w_seg_on;

endmodule

// File: rtl/lfsr_rx_checker.sv
// Self-synchronising checker for the 8-bit LFSR bit stream; counts mismatched beats.
module lfsr_rx_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH       = LFSR_W,
    parameter int unsigned LOSS_THRESH = 3
) (
    input  logic              sw_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [7:0]        err_cnt,
    output logic [7:0]        seg_led0,
    output logic [7:0]        seg_led1,
    output logic [LFSR_W-1:0] ledr
);

    localparam int unsigned FILL_W = $clog2(WIDTH + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESH);

    state_e            r_state, w_state_d;
    logic [LFSR_W-1:0] r_win, w_win_d;
    logic [FILL_W-1:0] r_fill, w_fill_d, w_fill_inc;
    logic [MISS_W-1:0] r_miss, w_miss_d, w_miss_inc;
    logic [7:0]        r_err_cnt, w_err_cnt_d;
    logic              r_err_pulse, w_err_pulse_d;
    logic              w_pred;

    // State register with synchronous reset.
    always_ff @(posedge sw_clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_win       <= '0;
            r_fill      <= '0;
            r_miss      <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_win       <= w_win_d;
            r_fill      <= w_fill_d;
            r_miss      <= w_miss_d;
            r_err_cnt   <= w_err_cnt_d;
            r_err_pulse <= w_err_pulse_d;
        end
    end

    // Hunt/lock next-state logic and error accounting, advanced only on valid beats.
    always_comb begin
        w_state_d     = r_state;
        w_win_d       = r_win;
        w_fill_d      = r_fill;
        w_miss_d      = r_miss;
        w_err_cnt_d   = r_err_cnt;
        w_err_pulse_d = 1'b0;
        w_pred        = predict_bit(r_win);
        w_fill_inc    = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
        w_miss_inc    = r_miss + 1'b1;

        if (in_valid) begin
            unique case (r_state)
                HUNT: begin
                    w_win_d  = {in_bit, r_win[LFSR_W-1:1]};
                    w_fill_d = w_fill_inc;
                    // An all-zero window is the LFSR lock-up state; keep hunting.
                    if ((w_fill_inc == FILL_FULL) && (w_win_d != '0)) begin
                        w_state_d = LOCKED;
                        w_miss_d  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the window follows the prediction, so a single bad
                    // bit does not poison the following predictions.
                    w_win_d = {w_pred, r_win[LFSR_W-1:1]};
                    if (in_bit == w_pred) begin
                        w_miss_d = '0;
                    end else begin
                        w_err_pulse_d = 1'b1;
                        if (r_err_cnt != 8'hff) begin
                            w_err_cnt_d = r_err_cnt + 8'd1;
                        end
                        if (w_miss_inc >= MISS_LIMIT) begin
                            w_state_d = HUNT;
                            w_fill_d  = '0;
                            w_win_d   = '0;
                            w_miss_d  = '0;
                        end else begin
                            w_miss_d = w_miss_inc;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Clear beats a same-cycle increment.
        if (clr_cnt) begin
            w_err_cnt_d = '0;
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign ledr      = r_win;

    seg u_seg_lo (
        .i_hex (r_err_cnt[3:0]),
        .o_seg (seg_led0)
    );

    seg u_seg_hi (
        .i_hex (r_err_cnt[7:4]),
        .o_seg (seg_led1)
    );

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// Scoreboard bench for lfsr_rx_checker: a reference model queues expected outputs per beat.
module tb_lfsr_rx_checker;
    import lfsr_pkg::*;

    localparam int LOSS = 3;

    typedef struct packed {
        logic       locked;
        logic       pulse;
        logic [7:0] cnt;
        logic [7:0] ledr;
    } exp_t;

    logic       sw_clk = 1'b0;
    logic       rst, in_valid, in_bit, clr_cnt;
    logic       locked, err_pulse;
    logic [7:0] err_cnt, seg_led0, seg_led1, ledr;

    int   n_checks = 0;
    int   n_errors = 0;
    int   pulse_seen;
    bit   gap_en;
    exp_t sb_q[$];

    // Reference model state
    bit         m_locked, m_pulse;
    logic [7:0] m_win;
    int         m_fill, m_miss, m_cnt;

    // Transmitter replica
    logic [7:0] tx_r;

    lfsr_rx_checker #(
        .WIDTH       (8),
        .LOSS_THRESH (LOSS)
    ) dut (
        .sw_clk    (sw_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .seg_led0  (seg_led0),
        .seg_led1  (seg_led1),
        .ledr      (ledr)
    );

    always #5 sw_clk = ~sw_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] seg_ref(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'h03;  4'h1: return 8'h9f;  4'h2: return 8'h25;  4'h3: return 8'h0d;
            4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1f;
            4'h8: return 8'h01;  4'h9: return 8'h09;  4'ha: return 8'h11;  4'hb: return 8'hc1;
            4'hc: return 8'h63;  4'hd: return 8'h85;  4'he: return 8'h61;  default: return 8'h71;
        endcase
    endfunction

    // Behavioural model of one clock edge.
    task automatic model_step(input logic v, input logic b, input logic clr, input logic r);
        logic p;
        m_pulse = 1'b0;
        if (r) begin
            m_locked = 1'b0; m_win = 8'h00; m_fill = 0; m_miss = 0; m_cnt = 0;
        end else begin
            if (v && !m_locked) begin
                m_win = {b, m_win[7:1]};
                if (m_fill < 8) m_fill++;
                if (m_fill == 8 && m_win != 8'h00) begin
                    m_locked = 1'b1;
                    m_miss   = 0;
                end
            end else if (v) begin
                p     = m_win[0] ^ m_win[2] ^ m_win[3] ^ m_win[4];
                m_win = {p, m_win[7:1]};
                if (b == p) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    m_miss++;
                    if (m_miss >= LOSS) begin
                        m_locked = 1'b0; m_fill = 0; m_win = 8'h00; m_miss = 0;
                    end
                end
            end
            if (clr) m_cnt = 0;
        end
    endtask

    // Drive one cycle, queue the model's expectation, then compare after the edge.
    task automatic drive(input logic v, input logic b, input logic clr, input logic r);
        exp_t e;
        in_valid = v; in_bit = b; clr_cnt = clr; rst = r;
        model_step(v, b, clr, r);
        sb_q.push_back('{locked: m_locked, pulse: m_pulse, cnt: m_cnt[7:0], ledr: m_win});
        @(posedge sw_clk);
        #1;
        e = sb_q.pop_front();
        check("sb_locked", 32'(locked), 32'(e.locked));
        check("sb_pulse", 32'(err_pulse), 32'(e.pulse));
        check("sb_cnt", 32'(err_cnt), 32'(e.cnt));
        check("sb_ledr", 32'(ledr), 32'(e.ledr));
        check("sb_seg0", 32'(seg_led0), 32'(seg_ref(e.cnt[3:0])));
        check("sb_seg1", 32'(seg_led1), 32'(seg_ref(e.cnt[7:4])));
        pulse_seen += int'(err_pulse);
    endtask

    // One transmitted stream bit, optionally inverted, with optional idle gaps first.
    task automatic tx_beat(input logic flip, input logic clr);
        logic b;
        int   g;
        if (gap_en) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        b    = tx_r[0] ^ flip;
        tx_r = {tx_r[4] ^ tx_r[3] ^ tx_r[2] ^ tx_r[0], tx_r[7:1]};
        drive(1'b1, b, clr, 1'b0);
    endtask

    task automatic do_reset();
        tx_r       = SEED;
        pulse_seen = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0; gap_en = 1'b0;

        // Reset state
        do_reset();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_pulse", 32'(err_pulse), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        check("rst_ledr", 32'(ledr), 32'd0);
        check("rst_seg0", 32'(seg_led0), 32'h03);
        check("rst_seg1", 32'(seg_led1), 32'h03);

        // Clean stream from the seed, with idle gaps
        gap_en = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tx_beat(1'b0, 1'b0);
            if (i == 7) check("t1_unlocked7", 32'(locked), 32'd0);
            if (i == 8) begin
                check("t1_locked8", 32'(locked), 32'd1);
                check("t1_win8", 32'(ledr), 32'(SEED));
            end
        end
        gap_en = 1'b0;
        check("t1_cnt", 32'(err_cnt), 32'd0);
        check("t1_pulses", 32'(pulse_seen), 32'd0);
        check("t1_locked", 32'(locked), 32'd1);

        // All-zero window must not lock
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_zero_unlocked", 32'(locked), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tx_beat(1'b0, 1'b0);
            if (i == 5) check("t2_still_unlocked", 32'(locked), 32'd0);
            if (i == 6) begin
                check("t2_locked", 32'(locked), 32'd1);
                check("t2_win", 32'(ledr), 32'h80);
            end
        end

        // Single flipped beat
        do_reset();
        for (int i = 1; i <= 80; i++) begin
            tx_beat(1'(i == 50), 1'b0);
            if (i == 50) begin
                check("t3_pulse", 32'(err_pulse), 32'd1);
                check("t3_cnt", 32'(err_cnt), 32'd1);
                check("t3_locked", 32'(locked), 32'd1);
            end
            if (i == 51) check("t3_pulse_off", 32'(err_pulse), 32'd0);
        end
        check("t3_cnt_end", 32'(err_cnt), 32'd1);
        check("t3_pulses", 32'(pulse_seen), 32'd1);

        // Three consecutive flips lose lock, then relock after 8 clean beats
        do_reset();
        for (int i = 0; i < 20; i++) tx_beat(1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tx_beat(1'b1, 1'b0);
            if (i == 2) check("t4_locked2", 32'(locked), 32'd1);
        end
        check("t4_cnt", 32'(err_cnt), 32'd3);
        check("t4_lost", 32'(locked), 32'd0);
        check("t4_win_clr", 32'(ledr), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tx_beat(1'b0, 1'b0);
            if (i == 7) check("t4_relock7", 32'(locked), 32'd0);
            if (i == 8) check("t4_relock8", 32'(locked), 32'd1);
        end
        for (int i = 0; i < 20; i++) tx_beat(1'b0, 1'b0);
        check("t4_cnt_end", 32'(err_cnt), 32'd3);

        // Saturation with isolated errors
        do_reset();
        for (int i = 0; i < 10; i++) tx_beat(1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            tx_beat(1'b1, 1'b0);
            if (i == 15) begin
                check("t5_cnt16", 32'(err_cnt), 32'd16);
                check("t5_seg0_16", 32'(seg_led0), 32'h03);
                check("t5_seg1_16", 32'(seg_led1), 32'h9f);
            end
            tx_beat(1'b0, 1'b0);
        end
        check("t5_sat", 32'(err_cnt), 32'd255);
        check("t5_locked", 32'(locked), 32'd1);
        check("t5_seg0", 32'(seg_led0), 32'h71);
        check("t5_seg1", 32'(seg_led1), 32'h71);

        // Clear coincident with a mismatch
        tx_beat(1'b1, 1'b1);
        check("t6_cnt", 32'(err_cnt), 32'd0);
        check("t6_pulse", 32'(err_pulse), 32'd1);
        tx_beat(1'b0, 1'b0);
        tx_beat(1'b1, 1'b0);
        check("t6_cnt1", 32'(err_cnt), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_clr_idle", 32'(err_cnt), 32'd0);

        // Reset while locked with errors
        do_reset();
        for (int i = 0; i < 10; i++) tx_beat(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tx_beat(1'b1, 1'b0);
            tx_beat(1'b0, 1'b0);
        end
        check("t7_cnt5", 32'(err_cnt), 32'd5);
        check("t7_locked", 32'(locked), 32'd1);
        drive(1'b1, ~tx_r[0], 1'b0, 1'b1);
        check("t7_locked_rst", 32'(locked), 32'd0);
        check("t7_cnt_rst", 32'(err_cnt), 32'd0);
        check("t7_ledr_rst", 32'(ledr), 32'd0);
        check("t7_pulse_rst", 32'(err_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rx_checker.md
# lfsr_rx_checker

Serial PRBS checker for the 8-bit right-shift LFSR stream produced by the board's random-number generator. It self-synchronises on the incoming bit stream, predicts each following bit, and counts mismatches. Errors show on the two seven-segment digits and the LED bar. It sits beside the generator in the NPC board top and closes the loop on a looped-back or externally supplied stream.

## Interface
- `WIDTH`, default 8: LFSR register width; the taps below are fixed for 8.
- `LOSS_THRESH`, default 3: consecutive mismatches in LOCKED that force resynchronisation.
- `sw_clk` input, 1: single clock; all state changes on the rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `in_valid` input, 1: `in_bit` is a stream beat this cycle.
- `in_bit` input, 1: serial stream bit. Transmitter sends `r[0]` each step, then shifts `r <= {r[4]^r[3]^r[2]^r[0], r[7:1]}`.
- `clr_cnt` input, 1: synchronous clear of `err_cnt`.
- `locked` output, 1: checker is in LOCKED.
- `err_pulse` output, 1: one-cycle flag for a mismatched beat.
- `err_cnt` output, 8: saturating mismatch count.
- `seg_led0` output, 8: seven-segment pattern of `err_cnt[3:0]`.
- `seg_led1` output, 8: seven-segment pattern of `err_cnt[7:4]`.
- `ledr` output, 8: current window register `w`, for debug.

## Operation
- Window `w[7:0]` holds the last 8 accepted bits, newest in `w[7]`. A shift is `w <= {b, w[7:1]}`.
- Stream identity: `s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4]`. Prediction is `p = w[0]^w[2]^w[3]^w[4]`.
- States are HUNT and LOCKED. Reset gives HUNT with `w=0`, `fill=0`, `miss=0`, `err_cnt=0`, and all outputs 0. `seg_led*` show the digit 0 pattern.
- HUNT behaviour:
  - Each valid beat shifts `in_bit` into `w`, and `fill` counts 0..8.
  - When `fill` reaches 8 and the new `w != 0`, go to LOCKED. Clear `miss`.
  - When `fill` reaches 8 and `w == 0`, stay in HUNT with `fill` held at 8. Each further beat re-tests the window.
  - No errors are counted in HUNT.
- LOCKED behaviour, per valid beat:
  - Compare `in_bit` with `p`.
  - Always shift `p` into `w`, not `in_bit`. This flywheel keeps one bit error from becoming several mismatches.
  - On a match, set `miss <= 0`.
  - On a mismatch: assert `err_pulse`, increment `err_cnt` saturating at 255, and increment `miss`.
  - When `miss` reaches `LOSS_THRESH`, go to HUNT with `fill=0` and `w=0`. `err_cnt` is kept.
- `in_valid=0`: no state change. `err_pulse=0`.
- `clr_cnt=1` sets `err_cnt <= 0` and wins over a same-cycle increment. `err_pulse` still fires for that beat.
- `rst` mid-operation returns everything to the reset state on the next edge, overriding all other inputs.

## Timing
- All outputs are registered.
- `err_pulse` is high exactly one cycle, the cycle after the offending beat's edge.
- `err_cnt` updates on that same edge.
- `locked` rises on the edge that accepts the 8th valid bit, so it is visible the following cycle. It falls on the edge that accepts the `LOSS_THRESH`-th consecutive mismatch.
- The beat that causes loss of lock is counted in `err_cnt`.
- `seg_led*` follow `err_cnt` through the shared decoder, adding no extra cycle beyond the `err_cnt` register.
- Gaps in `in_valid` of any length are transparent; only valid beats count.

## Structure
- Package `lfsr_pkg`: `LFSR_W=8`, tap mask `8'b0001_1101` over `w[4:0]` (bits 0, 2, 3, 4), seed constant `8'h20`, state enum `{HUNT, LOCKED}`.
- Reuse the existing `seg` hex-to-seven-segment decoder, two instances. No new sub-module; the checker FSM and datapath stay in one module.

## Test plan
- Feed the stream from seed 0x20: first bits 0,0,0,0,0,1,0,0, then continue for 300 beats. Required: `locked=1` from cycle after beat 8, `err_cnt=0`, `err_pulse` never high.
- Eight zero beats after reset. Required: `locked` stays 0 and `fill` holds at 8. The next correct nonzero stream locks once the window becomes nonzero.
- Locked stream, flip beat 50. Required: one `err_pulse`, `err_cnt=1`, `locked` stays 1, and following beats match.
- Locked stream, flip 3 consecutive beats. Required: `err_cnt=3`, `locked` falls after the third beat, and relock happens 8 clean beats later.
- Force 260 isolated mismatches, with a good beat between each. Required: `err_cnt` saturates at 255.
- `clr_cnt` pulse coincident with a mismatch. Required: `err_cnt=0` and `err_pulse=1`.
- Assert `rst` while locked with `err_cnt=5`. Required: next cycle `locked=0`, `err_cnt=0`, `ledr=0`.
